// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ
// valid/ready byte streams, with packet locking, guard gap and done watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_en_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i,
  output logic [2:0]           grant_id_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t               state, state_n;
  logic                 lock, lock_n;
  logic [2:0]           last_grant, last_grant_n;
  logic [TW-1:0]        timer, timer_n;
  logic [GW-1:0]        gap_cnt, gap_cnt_n;
  logic [NUM_REQ-1:0]   ready_n;
  logic                 tx_en_n, err_n, busy_n;
  logic [7:0]           data_n;
  logic [2:0]           grant_n;

  logic                 sel_valid, sel_last;
  logic [7:0]           sel_data;
  logic                 rr_found;
  logic [2:0]           rr_idx;
  int unsigned          rr_cand;

  // Signals of the currently granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_o == 3'(i)) begin
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
        sel_data  = req_data_i[8*i +: 8];
      end
    end
  end

  // First valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_cand = 32'(last_grant) + k;
      if (rr_cand >= NUM_REQ) rr_cand = rr_cand - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!rr_found && (j == rr_cand) && req_valid_i[j]) begin
          rr_found = 1'b1;
          rr_idx   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    state_n      = state;
    lock_n       = lock;
    last_grant_n = last_grant;
    timer_n      = timer;
    gap_cnt_n    = gap_cnt;
    grant_n      = grant_id_o;
    data_n       = tx_data_o;
    ready_n      = '0;
    tx_en_n      = 1'b0;
    err_n        = 1'b0;

    unique case (state)
      IDLE: begin
        if (lock) begin
          if (sel_valid) state_n = ISSUE;
        end else if (rr_found) begin
          grant_n = rr_idx;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tx_en_n = 1'b1;
        data_n  = sel_data;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          ready_n[i] = (grant_id_o == 3'(i));
        end
        lock_n       = ~sel_last;
        last_grant_n = grant_id_o;
        timer_n      = '0;
        state_n      = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Done on the terminal count takes priority over the abort.
        if (tx_done_i) begin
          gap_cnt_n = '0;
          state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (timer == T_LAST) begin
          err_n   = 1'b1;
          lock_n  = 1'b0;
          state_n = IDLE;
        end else if (timer != '1) begin
          timer_n = timer + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt >= GAP_LAST) begin
          state_n = IDLE;
        end else if (gap_cnt != '1) begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lock          <= 1'b0;
      last_grant    <= 3'(NUM_REQ - 1);
      timer         <= '0;
      gap_cnt       <= '0;
      req_ready_o   <= '0;
      tx_en_o       <= 1'b0;
      tx_data_o     <= 8'h00;
      grant_id_o    <= '0;
      busy_o        <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      state         <= state_n;
      lock          <= lock_n;
      last_grant    <= last_grant_n;
      timer         <= timer_n;
      gap_cnt       <= gap_cnt_n;
      req_ready_o   <= ready_n;
      tx_en_o       <= tx_en_n;
      tx_data_o     <= data_n;
      grant_id_o    <= grant_n;
      busy_o        <= busy_n;
      err_timeout_o <= err_n;
    end
  end

endmodule
